// File: rtl/reg_file_bank.sv
// reg_file_bank: NUM_REGS x WIDTH register file, 2 async reads, 1 byte-masked sync write, saturating write counter.
// Define REG_FILE_BYPASS_EN for write-before-read forwarding on same-address read/write.
module reg_file_bank #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   WriteAddr,
  input  logic [WIDTH-1:0]    Data,
  input  logic [WIDTH/8-1:0]  ByteEn,
  input  logic [ADDR_W-1:0]   ReadAddr1,
  input  logic [ADDR_W-1:0]   ReadAddr2,
  output logic [WIDTH-1:0]    Dout1,
  output logic [WIDTH-1:0]    Dout2,
  output logic [CNT_W-1:0]    WrCount
);
  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;
  logic             w_commit;
  for (genvar b = 0; b < WIDTH/8; b++) begin : g_mask
    assign w_mask[8*b +: 8] = {8{ByteEn[b]}};
  end
  // a commit excludes hardwired reg 0, so forwarding never leaks data onto address 0
  assign w_commit = RST_N && WE && (|ByteEn) && !((ZERO_REG != 0) && (WriteAddr == '0));
  assign w_merged = (Data & w_mask) | (r_regs[WriteAddr] & ~w_mask);
  assign w_rd1 = ((ZERO_REG != 0) && (ReadAddr1 == '0)) ? '0 : r_regs[ReadAddr1];
  assign w_rd2 = ((ZERO_REG != 0) && (ReadAddr2 == '0)) ? '0 : r_regs[ReadAddr2];
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_cnt <= '0;
    end else if (w_commit) begin
      r_regs[WriteAddr] <= w_merged;
      if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`ifdef REG_FILE_BYPASS_EN
  assign Dout1 = (w_commit && (ReadAddr1 == WriteAddr)) ? w_merged : w_rd1;
  assign Dout2 = (w_commit && (ReadAddr2 == WriteAddr)) ? w_merged : w_rd2;
`else
  assign Dout1 = w_rd1;
  assign Dout2 = w_rd2;
`endif
  assign WrCount = r_cnt;
endmodule
